// File: rtl/mem_ctrl_pkg.sv
// Shared types and default sizing for the LC-3 wait-state memory controller.
package mem_ctrl_pkg;

  localparam int unsigned LC3_DATA_W    = 16;
  localparam int unsigned LC3_ADDR_W    = 16;
  localparam int unsigned LC3_MEM_DEPTH = 256;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/lc3_mem_array.sv
// LC-3 main-memory storage: synchronous write, combinational read port sampled
// by the controller. Contents are deliberately not reset.
module lc3_mem_array
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W = LC3_DATA_W,
  parameter int unsigned DEPTH  = LC3_MEM_DEPTH,
  parameter int unsigned IDX_W  = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata_c
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[addr] <= wdata;
  end

  assign rdata_c = mem_q[addr];

endmodule

// File: rtl/mem_ctrl_ws.sv
// LC-3 memory controller with memEN/memWE request, programmable wait states,
// registered read data, one-cycle memR ready pulse and out-of-range flag.
module mem_ctrl_ws
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W      = LC3_DATA_W,
  parameter int unsigned ADDR_W      = LC3_ADDR_W,
  parameter int unsigned DEPTH       = LC3_MEM_DEPTH,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              memEN,
  input  logic              memWE,
  input  logic [ADDR_W-1:0] MARReg,
  input  logic [DATA_W-1:0] mdrOut,
  output logic [DATA_W-1:0] memOut,
  output logic              memR,
  output logic              memErr
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] mem_out_q, mem_out_d;
  logic              mem_r_q, mem_r_d;
  logic              mem_err_q, mem_err_d;

  logic              in_range_c;
  logic              arr_we_c;
  logic [DATA_W-1:0] rdata_c;

  // Range check on the captured address; array is indexed only when it passes.
  assign in_range_c = ({1'b0, addr_q} < (ADDR_W + 1)'(DEPTH));

  lc3_mem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_array (
    .clk     (clk),
    .we      (arr_we_c),
    .addr    (addr_q[IDX_W-1:0]),
    .wdata   (data_q),
    .rdata_c (rdata_c)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      we_q      <= 1'b0;
      mem_out_q <= '0;
      mem_r_q   <= 1'b0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      we_q      <= we_d;
      mem_out_q <= mem_out_d;
      mem_r_q   <= mem_r_d;
      mem_err_q <= mem_err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    data_d    = data_q;
    we_d      = we_q;
    mem_out_d = mem_out_q;
    mem_r_d   = 1'b0;
    mem_err_d = 1'b0;
    arr_we_c  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (memEN) begin
          addr_d  = MARReg;
          data_d  = mdrOut;
          we_d    = memWE;
          cnt_d   = CNT_W'(WAIT_CYCLES);
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          // Completing edge: access the array and raise the ready pulse.
          state_d   = DONE;
          mem_r_d   = 1'b1;
          mem_err_d = ~in_range_c;
          if (we_q) begin
            arr_we_c = in_range_c;
          end else begin
            mem_out_d = in_range_c ? rdata_c : '0;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign memOut = mem_out_q;
  assign memR   = mem_r_q;
  assign memErr = mem_err_q;

endmodule

// File: tb/tb_mem_ctrl_ws.sv
// Directed bench for mem_ctrl_ws: a WAIT_CYCLES=2 instance and a zero-wait instance.
module tb_mem_ctrl_ws;

  logic        clk = 1'b0;
  logic        reset = 1'b0;

  logic        en2 = 1'b0, we2 = 1'b0;
  logic [15:0] mar2 = '0, mdr2 = '0;
  logic [15:0] out2;
  logic        r2, err2;

  logic        en0 = 1'b0, we0 = 1'b0;
  logic [15:0] mar0 = '0, mdr0 = '0;
  logic [15:0] out0;
  logic        r0, err0;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  mem_ctrl_ws #(.DATA_W(16), .ADDR_W(16), .DEPTH(256), .WAIT_CYCLES(2)) u_dut (
    .clk(clk), .reset(reset), .memEN(en2), .memWE(we2), .MARReg(mar2),
    .mdrOut(mdr2), .memOut(out2), .memR(r2), .memErr(err2)
  );

  mem_ctrl_ws #(.DATA_W(16), .ADDR_W(16), .DEPTH(256), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .reset(reset), .memEN(en0), .memWE(we0), .MARReg(mar0),
    .mdrOut(mdr0), .memOut(out0), .memR(r0), .memErr(err0)
  );

  // One request to the selected instance (sel=1 -> zero-wait); reports the cycle
  // count to memR, the sampled outputs, and whether the pulse ended after one cycle.
  task automatic issue(input bit sel, input logic we, input logic [15:0] addr,
                       input logic [15:0] data, output int n, output logic [15:0] dout,
                       output logic err, output bit pulse_ok);
    n = -1; dout = 'x; err = 'x; pulse_ok = 1'b0;
    @(negedge clk);
    if (sel) begin en0 = 1'b1; we0 = we; mar0 = addr; mdr0 = data; end
    else     begin en2 = 1'b1; we2 = we; mar2 = addr; mdr2 = data; end
    @(posedge clk); #1;
    en0 = 1'b0; en2 = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if ((sel ? r0 : r2) === 1'b1) begin
        n = i;
        dout = sel ? out0 : out2;
        err = sel ? err0 : err2;
        break;
      end
    end
    if (n > 0) begin
      @(posedge clk); #1;
      pulse_ok = sel ? (r0 === 1'b0 && err0 === 1'b0) : (r2 === 1'b0 && err2 === 1'b0);
    end
  endtask

  task automatic test_reset_initial();
    #1 reset = 1'b1;
    #2;
    compared++;
    if (out2 !== 16'h0000 || r2 !== 1'b0 || err2 !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_init_dut2: got out=%h r=%b err=%b expected out=0000 r=0 err=0", out2, r2, err2);
    end
    compared++;
    if (out0 !== 16'h0000 || r0 !== 1'b0 || err0 !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_init_dut0: got out=%h r=%b err=%b expected out=0000 r=0 err=0", out0, r0, err0);
    end
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic test_write_read();
    int n; logic [15:0] d; logic e; bit ok;
    issue(1'b0, 1'b1, 16'h0012, 16'hBEEF, n, d, e, ok);
    compared++;
    if (n !== 3 || e !== 1'b0 || !ok) begin
      mismatched++;
      $display("FAIL wr_0012: got lat=%0d err=%b pulse_ok=%0d expected lat=3 err=0 pulse_ok=1", n, e, ok);
    end
    compared++;
    if (d !== 16'h0000) begin
      mismatched++;
      $display("FAIL wr_no_memout: got %h expected 0000", d);
    end
    issue(1'b0, 1'b0, 16'h0012, 16'h0000, n, d, e, ok);
    compared++;
    if (n !== 3 || d !== 16'hBEEF || e !== 1'b0 || !ok) begin
      mismatched++;
      $display("FAIL rd_0012: got lat=%0d data=%h err=%b pulse_ok=%0d expected lat=3 data=beef err=0 pulse_ok=1", n, d, e, ok);
    end
  endtask

  task automatic test_zero_wait();
    int n; logic [15:0] d; logic e; bit ok;
    issue(1'b1, 1'b1, 16'h00FF, 16'h1234, n, d, e, ok);
    compared++;
    if (n !== 1 || e !== 1'b0 || !ok) begin
      mismatched++;
      $display("FAIL zw_wr_00ff: got lat=%0d err=%b pulse_ok=%0d expected lat=1 err=0 pulse_ok=1", n, e, ok);
    end
    issue(1'b1, 1'b0, 16'h00FF, 16'h0000, n, d, e, ok);
    compared++;
    if (n !== 1 || d !== 16'h1234 || e !== 1'b0 || !ok) begin
      mismatched++;
      $display("FAIL zw_rd_00ff: got lat=%0d data=%h err=%b expected lat=1 data=1234 err=0", n, d, e);
    end
  endtask

  task automatic test_out_of_range();
    int n; logic [15:0] d; logic e; bit ok;
    issue(1'b0, 1'b1, 16'h0000, 16'h5555, n, d, e, ok);
    issue(1'b0, 1'b1, 16'h0100, 16'hAAAA, n, d, e, ok);
    compared++;
    if (n !== 3 || e !== 1'b1 || !ok) begin
      mismatched++;
      $display("FAIL oor_wr_0100: got lat=%0d err=%b pulse_ok=%0d expected lat=3 err=1 pulse_ok=1", n, e, ok);
    end
    issue(1'b0, 1'b0, 16'h0000, 16'h0000, n, d, e, ok);
    compared++;
    if (d !== 16'h5555 || e !== 1'b0) begin
      mismatched++;
      $display("FAIL oor_alias_0000: got data=%h err=%b expected data=5555 err=0", d, e);
    end
    issue(1'b0, 1'b0, 16'h0100, 16'h0000, n, d, e, ok);
    compared++;
    if (n !== 3 || d !== 16'h0000 || e !== 1'b1) begin
      mismatched++;
      $display("FAIL oor_rd_0100: got lat=%0d data=%h err=%b expected lat=3 data=0000 err=1", n, d, e);
    end
  endtask

  task automatic test_busy_ignore();
    int n; logic [15:0] d; logic e; bit ok;
    int pulses = 0;
    issue(1'b0, 1'b1, 16'h0031, 16'h1111, n, d, e, ok);
    @(negedge clk);
    en2 = 1'b1; we2 = 1'b1; mar2 = 16'h0030; mdr2 = 16'hC0DE;
    @(posedge clk); #1;
    en2 = 1'b0;
    // Wiggle inputs through BUSY and DONE; memEN drops before IDLE resamples it.
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk); #1;
      if (r2 === 1'b1) pulses++;
      en2 = (i == 1 || i == 3);
      we2 = i[0];
      mar2 = 16'h0031;
      mdr2 = 16'hFFFF - 16'(i);
      if (i >= 4) en2 = 1'b0;
    end
    compared++;
    if (pulses !== 1) begin
      mismatched++;
      $display("FAIL busy_pulses: got %0d expected 1", pulses);
    end
    issue(1'b0, 1'b0, 16'h0030, 16'h0000, n, d, e, ok);
    compared++;
    if (d !== 16'hC0DE || e !== 1'b0) begin
      mismatched++;
      $display("FAIL busy_captured_0030: got data=%h err=%b expected data=c0de err=0", d, e);
    end
    issue(1'b0, 1'b0, 16'h0031, 16'h0000, n, d, e, ok);
    compared++;
    if (d !== 16'h1111) begin
      mismatched++;
      $display("FAIL busy_untouched_0031: got %h expected 1111", d);
    end
  endtask

  task automatic test_reset_mid_access();
    int n; logic [15:0] d; logic e; bit ok;
    int seen = 0;
    issue(1'b0, 1'b1, 16'h0020, 16'h0001, n, d, e, ok);
    @(negedge clk);
    en2 = 1'b1; we2 = 1'b1; mar2 = 16'h0020; mdr2 = 16'h7777;
    @(posedge clk); #1;
    en2 = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (6) begin
      @(posedge clk); #1;
      if (r2 === 1'b1) seen++;
    end
    @(negedge clk); reset = 1'b0;
    compared++;
    if (seen !== 0) begin
      mismatched++;
      $display("FAIL abort_no_memr: got %0d pulses expected 0", seen);
    end
    issue(1'b0, 1'b0, 16'h0020, 16'h0000, n, d, e, ok);
    compared++;
    if (n !== 3 || d !== 16'h0001) begin
      mismatched++;
      $display("FAIL abort_no_write: got lat=%0d data=%h expected lat=3 data=0001", n, d);
    end
  endtask

  task automatic test_reset_outputs();
    int n = -1;
    @(negedge clk);
    en2 = 1'b1; we2 = 1'b0; mar2 = 16'h0012;
    @(posedge clk); #1;
    en2 = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (r2 === 1'b1) begin n = i; break; end
    end
    compared++;
    if (n !== 3 || out2 !== 16'hBEEF) begin
      mismatched++;
      $display("FAIL pre_reset_read: got lat=%0d data=%h expected lat=3 data=beef", n, out2);
    end
    #2 reset = 1'b1;
    #1;
    compared++;
    if (out2 !== 16'h0000 || r2 !== 1'b0 || err2 !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_async: got out=%h r=%b err=%b expected out=0000 r=0 err=0", out2, r2, err2);
    end
    @(negedge clk); reset = 1'b0;
  endtask

  initial begin
    test_reset_initial();
    test_write_read();
    test_zero_wait();
    test_out_of_range();
    test_busy_ignore();
    test_reset_mid_access();
    test_reset_outputs();
    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/mem_ctrl_ws.md
Name: mem_ctrl_ws

Overview:
Parametrised LC-3 main-memory block with a request/ready handshake and configurable wait states. It replaces the zero-latency, combinational-read RAM with a registered-read, multi-cycle access. The control FSM uses memEN/memWE and waits on memR, matching the LC-3 ready bit (R) semantics. Depth, data width, address width and wait-state count are configurable, and out-of-range addresses are detected.

Parameters:
DATA_W, 16, data word width
ADDR_W, 16, MAR width
DEPTH, 256, number of implemented words; addresses 0..DEPTH-1 are valid; must be ≤ 2**ADDR_W
WAIT_CYCLES, 2, extra busy cycles before access completes; 0 allowed

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
memEN  input  1  request strobe; sampled only in IDLE
memWE  input  1  1 = write, 0 = read; captured with memEN
MARReg  input  ADDR_W  access address; captured with memEN
mdrOut  input  DATA_W  write data; captured with memEN
memOut  output  DATA_W  registered read data
memR  output  1  ready pulse; high exactly one cycle per completed access
memErr  output  1  out-of-range flag; valid while memR is high

Behaviour:
- Reset (async, any state): state=IDLE, wait counter=0, memOut=0, memR=0, memErr=0. Array contents are not cleared.
- FSM states: IDLE, BUSY, DONE.
- IDLE: on a clk edge with memEN=1, capture MARReg, mdrOut and memWE. Load counter with WAIT_CYCLES and go to BUSY. With memEN=0, stay in IDLE.
- BUSY, counter≠0: decrement the counter and stay in BUSY.
- BUSY, counter=0: perform the access on this edge, set memR=1 and memErr, go to DONE.
- DONE: memR=1 for this single cycle. The next edge returns to IDLE with memR=0 and memErr=0. memEN is not accepted in DONE.
- Latency: request accepted at edge E0 → memR high during the cycle after edge E0+WAIT_CYCLES+1.
  - Back-to-back requests: minimum spacing is WAIT_CYCLES+3 cycles.
- memEN, memWE, MARReg and mdrOut are ignored in BUSY and DONE. Captured values are used, so mid-access input changes have no effect.
- Read: memOut loads array[addr] at the completing edge. memOut holds its value until the next completed read; writes do not change memOut.
- Write: array[addr] ← captured data at the completing edge.
- Out of range (captured addr ≥ DEPTH):
  - write is suppressed;
  - a read loads memOut=0;
  - memErr=1 alongside memR;
  - timing is identical to a valid access.
- Array index uses addr[$clog2(DEPTH)-1:0] only after the range check passes.
- Reset asserted before the completing edge aborts the access: no write occurs and memR is never raised.
- Asserting memEN in the same cycle that reset deasserts is undefined; the bench holds memEN=0 for one cycle after reset.

Decomposition:
- Package mem_ctrl_pkg:
  - state enum typedef (IDLE, BUSY, DONE);
  - default constants LC3_DATA_W=16, LC3_ADDR_W=16, LC3_MEM_DEPTH=256.
- Sub-module lc3_mem_array: DEPTH×DATA_W storage, synchronous write enable, read port sampled by the controller. No reset.
- mem_ctrl_ws contains the FSM, wait counter, capture registers, range check and output registers.

Test Plan:
1. Reset values: assert reset mid-cycle → memOut=16'h0000, memR=0, memErr=0 immediately, before the next clk edge.
2. Write then read, WAIT_CYCLES=2: write 16'hBEEF to 16'h0012; memR high on the 4th cycle after memEN. Then read 16'h0012 → memOut=16'hBEEF with memR, memErr=0.
3. Zero-wait configuration, WAIT_CYCLES=0: write 16'h1234 to 16'h00FF, then read it → memR on the 2nd cycle after memEN each time; memOut=16'h1234.
4. Out-of-range, DEPTH=256: write 16'hAAAA to 16'h0100 → memR with memErr=1. Then read 16'h0000 (preloaded 16'h5555) → 16'h5555, array unchanged. Read 16'h0100 → memOut=0, memErr=1.
5. Busy ignore: during BUSY, toggle memEN and change MARReg and mdrOut → exactly one memR pulse; the captured address is written with the captured data.
6. Reset mid-access: write 16'h7777 to 16'h0020 (old value 16'h0001), assert reset while BUSY → no memR. A later read of 16'h0020 returns 16'h0001.
